// File: rtl/char_ram_pkg.sv
// Shared constants, write-buffer entry type and grant states for the
// character RAM arbiter.
package char_ram_pkg;

  localparam int          DATA_W    = 8;
  localparam int          ADDR_W    = 6;
  localparam int          N_CHARS   = 41;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0400;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_RD,
    GNT_WR
  } grant_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous first-word-fall-through FIFO with occupancy count.
// Pushes into a full FIFO and pops from an empty one are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LVL_FULL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/char_ram_arbiter.sv
// Arbitrates one single-port character RAM between VGA reads (absolute
// priority) and buffered processor stores into the character window.
module char_ram_arbiter
  import char_ram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock_50,
  input  logic                          reset,
  input  logic                          cpu_we,
  input  logic [31:0]                   cpu_addr,
  input  logic [31:0]                   cpu_wdata,
  output logic                          cpu_stall,
  input  logic                          vga_req,
  input  logic [ADDR_W-1:0]             vga_addr,
  output logic [DATA_W-1:0]             vga_rdata,
  output logic                          vga_rvalid,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic [DATA_W-1:0]             ram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow_err
);

  logic [31:0]       w_offset;
  logic              w_in_win;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  wr_entry_t         w_entry_in;
  wr_entry_t         w_head;
  logic              w_unused;

  grant_e            r_state;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_vld_p1;
  logic              r_vld_p2;
  logic [DATA_W-1:0] r_rdata_p2;
  logic              r_ovf;

  // The subtraction wraps for addresses below the window, so the lower
  // bound is checked separately.
  assign w_offset = cpu_addr - BASE_ADDR;
  assign w_in_win = cpu_we & (cpu_addr >= BASE_ADDR) & (w_offset < 32'(N_CHARS));

  assign w_entry_in.idx  = w_offset[ADDR_W-1:0];
  assign w_entry_in.data = cpu_wdata[DATA_W-1:0];

  // Full is registered, so a drain on this edge cannot admit this cycle's store.
  assign cpu_stall = w_in_win & w_full;
  assign w_push    = w_in_win & ~w_full;
  assign w_pop     = ~vga_req & ~w_empty;

  assign w_unused = ^{cpu_wdata[31:DATA_W]};

  sync_fifo #(
    .WIDTH ($bits(wr_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .i_clk   (clock_50),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_wdata (w_entry_in),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  // Stage p0: grant decision, registered onto the RAM port for the next cycle.
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      r_state     <= GNT_IDLE;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      if (vga_req) begin
        r_state    <= GNT_RD;
        r_ram_en   <= 1'b1;
        r_ram_we   <= 1'b0;
        r_ram_addr <= vga_addr;
      end else if (!w_empty) begin
        r_state     <= GNT_WR;
        r_ram_en    <= 1'b1;
        r_ram_we    <= 1'b1;
        r_ram_addr  <= w_head.idx;
        r_ram_wdata <= w_head.data;
      end else begin
        r_state  <= GNT_IDLE;
        r_ram_en <= 1'b0;
        r_ram_we <= 1'b0;
      end
    end
  end

  // Stage p1: RAM access cycle; stage p2: read data captured for the VGA side.
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_rdata_p2 <= '0;
    end else begin
      r_vld_p1 <= (r_state == GNT_RD);
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_rdata_p2 <= ram_rdata;
      end
    end
  end

  // Sticky until reset; any stalled cycle sets it, the first one included.
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (cpu_stall) begin
      r_ovf <= 1'b1;
    end
  end

  assign ram_en       = r_ram_en;
  assign ram_we       = r_ram_we;
  assign ram_addr     = r_ram_addr;
  assign ram_wdata    = r_ram_wdata;
  assign vga_rvalid   = r_vld_p2;
  assign vga_rdata    = r_rdata_p2;
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_char_ram_arbiter.sv
// Directed bench for char_ram_arbiter: vector table plus hand sequences for
// overflow/drain, same-index ordering and mid-traffic reset.
module tb_char_ram_arbiter;
  import char_ram_pkg::*;

  logic              clock_50 = 1'b0;
  logic              reset = 1'b0;
  logic              cpu_we = 1'b0;
  logic [31:0]       cpu_addr = '0;
  logic [31:0]       cpu_wdata = '0;
  logic              cpu_stall;
  logic              vga_req = 1'b0;
  logic [ADDR_W-1:0] vga_addr = '0;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_rvalid;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [2:0]        fifo_level;
  logic              overflow_err;

  logic              ram_load = 1'b1;
  logic [DATA_W-1:0] mem [64];

  int n_vec = 0;
  int n_miss = 0;

  char_ram_arbiter #(.FIFO_DEPTH(4)) dut (
    .clock_50     (clock_50),
    .reset        (reset),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_stall    (cpu_stall),
    .vga_req      (vga_req),
    .vga_addr     (vga_addr),
    .vga_rdata    (vga_rdata),
    .vga_rvalid   (vga_rvalid),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .fifo_level   (fifo_level),
    .overflow_err (overflow_err)
  );

  always #5 clock_50 = ~clock_50;

  // Single-port RAM model, registered read, preloaded with 0x10 + index.
  always @(posedge clock_50) begin
    if (ram_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(16 + i);
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wd;
    logic        req;
    logic [5:0]  raddr;
    logic        x_stall;
    logic        x_en;
    logic        x_we;
    logic [5:0]  x_addr;
    logic [7:0]  x_wdata;
    logic [2:0]  x_lvl;
    logic        x_rv;
    logic [7:0]  x_rdata;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_50);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ram_en"},       32'(ram_en), 32'd0);
    chk({tag, " ram_we"},       32'(ram_we), 32'd0);
    chk({tag, " ram_addr"},     32'(ram_addr), 32'd0);
    chk({tag, " ram_wdata"},    32'(ram_wdata), 32'd0);
    chk({tag, " vga_rvalid"},   32'(vga_rvalid), 32'd0);
    chk({tag, " vga_rdata"},    32'(vga_rdata), 32'd0);
    chk({tag, " fifo_level"},   32'(fifo_level), 32'd0);
    chk({tag, " overflow_err"}, 32'(overflow_err), 32'd0);
    chk({tag, " cpu_stall"},    32'(cpu_stall), 32'd0);
  endtask

  task automatic chk_wr(input string tag, input logic [5:0] a, input logic [7:0] d,
                        input logic [2:0] lvl);
    chk({tag, " ram_en"},     32'(ram_en), 32'd1);
    chk({tag, " ram_we"},     32'(ram_we), 32'd1);
    chk({tag, " ram_addr"},   32'(ram_addr), 32'(a));
    chk({tag, " ram_wdata"},  32'(ram_wdata), 32'(d));
    chk({tag, " fifo_level"}, 32'(fifo_level), 32'(lvl));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    //        we    addr        wd     req   raddr  stall en    we    addr    wdata  lvl   rv    rdata
    tbl[0]  = '{1'b0, 32'h0,   8'h0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  8'h0,  3'd0, 1'b0, 8'h0};
    tbl[1]  = '{1'b0, 32'h0,   8'h0,  1'b1, 6'd3,  1'b0, 1'b1, 1'b0, 6'd3,  8'h0,  3'd0, 1'b0, 8'h0};
    tbl[2]  = '{1'b0, 32'h0,   8'h0,  1'b1, 6'd4,  1'b0, 1'b1, 1'b0, 6'd4,  8'h0,  3'd0, 1'b0, 8'h0};
    tbl[3]  = '{1'b0, 32'h0,   8'h0,  1'b1, 6'd5,  1'b0, 1'b1, 1'b0, 6'd5,  8'h0,  3'd0, 1'b1, 8'h13};
    tbl[4]  = '{1'b0, 32'h0,   8'h0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  8'h0,  3'd0, 1'b1, 8'h14};
    tbl[5]  = '{1'b0, 32'h0,   8'h0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  8'h0,  3'd0, 1'b1, 8'h15};
    tbl[6]  = '{1'b0, 32'h0,   8'h0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  8'h0,  3'd0, 1'b0, 8'h0};
    tbl[7]  = '{1'b1, 32'h405, 8'h41, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  8'h0,  3'd1, 1'b0, 8'h0};
    tbl[8]  = '{1'b0, 32'h0,   8'h0,  1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 6'd5,  8'h41, 3'd0, 1'b0, 8'h0};
    tbl[9]  = '{1'b0, 32'h0,   8'h0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  8'h0,  3'd0, 1'b0, 8'h0};
    tbl[10] = '{1'b1, 32'h3FF, 8'h55, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  8'h0,  3'd0, 1'b0, 8'h0};
    tbl[11] = '{1'b1, 32'h429, 8'h66, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  8'h0,  3'd0, 1'b0, 8'h0};
    tbl[12] = '{1'b1, 32'h428, 8'h77, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  8'h0,  3'd1, 1'b0, 8'h0};
    tbl[13] = '{1'b0, 32'h0,   8'h0,  1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 6'd40, 8'h77, 3'd0, 1'b0, 8'h0};
    tbl[14] = '{1'b0, 32'h0,   8'h0,  1'b1, 6'd40, 1'b0, 1'b1, 1'b0, 6'd40, 8'h0,  3'd0, 1'b0, 8'h0};
    tbl[15] = '{1'b0, 32'h0,   8'h0,  1'b1, 6'd5,  1'b0, 1'b1, 1'b0, 6'd5,  8'h0,  3'd0, 1'b0, 8'h0};
    tbl[16] = '{1'b0, 32'h0,   8'h0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  8'h0,  3'd0, 1'b1, 8'h77};
    tbl[17] = '{1'b0, 32'h0,   8'h0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  8'h0,  3'd0, 1'b1, 8'h41};
    tbl[18] = '{1'b0, 32'h0,   8'h0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  8'h0,  3'd0, 1'b0, 8'h0};

    // Power-on reset state
    repeat (3) tick();
    chk_all_zero("reset");
    ram_load = 1'b0;
    reset    = 1'b1;

    // Table: reads, single store, window boundaries, write-then-read
    for (int i = 0; i < 19; i++) begin
      cpu_we    = tbl[i].we;
      cpu_addr  = tbl[i].addr;
      cpu_wdata = {24'h0, tbl[i].wd};
      vga_req   = tbl[i].req;
      vga_addr  = tbl[i].raddr;
      #1;
      chk($sformatf("v%0d cpu_stall", i), 32'(cpu_stall), 32'(tbl[i].x_stall));
      tick();
      chk($sformatf("v%0d ram_en", i), 32'(ram_en), 32'(tbl[i].x_en));
      chk($sformatf("v%0d ram_we", i), 32'(ram_we), 32'(tbl[i].x_we));
      if (tbl[i].x_en)
        chk($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(tbl[i].x_addr));
      if (tbl[i].x_en && tbl[i].x_we)
        chk($sformatf("v%0d ram_wdata", i), 32'(ram_wdata), 32'(tbl[i].x_wdata));
      chk($sformatf("v%0d fifo_level", i), 32'(fifo_level), 32'(tbl[i].x_lvl));
      chk($sformatf("v%0d vga_rvalid", i), 32'(vga_rvalid), 32'(tbl[i].x_rv));
      if (tbl[i].x_rv)
        chk($sformatf("v%0d vga_rdata", i), 32'(vga_rdata), 32'(tbl[i].x_rdata));
      chk($sformatf("v%0d overflow_err", i), 32'(overflow_err), 32'd0);
    end

    // Two stores to index 7, drained in order, then read back
    cpu_we = 1'b1; cpu_addr = 32'h407; cpu_wdata = 32'h01;
    tick();
    chk("same7 level1", 32'(fifo_level), 32'd1);
    cpu_wdata = 32'h02;
    tick();
    chk_wr("same7 first", 6'd7, 8'h01, 3'd1);
    cpu_we = 1'b0;
    tick();
    chk_wr("same7 second", 6'd7, 8'h02, 3'd0);
    tick();
    chk("same7 idle en", 32'(ram_en), 32'd0);
    vga_req = 1'b1; vga_addr = 6'd7;
    tick();
    vga_req = 1'b0;
    tick();
    chk("same7 rvalid early", 32'(vga_rvalid), 32'd0);
    tick();
    chk("same7 rvalid", 32'(vga_rvalid), 32'd1);
    chk("same7 rdata", 32'(vga_rdata), 32'h02);
    tick();
    chk("same7 rvalid one-shot", 32'(vga_rvalid), 32'd0);

    // Overflow under continuous VGA reads, then drain and stall release
    vga_req = 1'b1; vga_addr = 6'd0;
    for (int i = 0; i < 5; i++) begin
      cpu_we = 1'b1; cpu_addr = 32'h400 + 32'(i); cpu_wdata = 32'hA0 + 32'(i);
      #1;
      chk($sformatf("ovf stall store%0d", i), 32'(cpu_stall), 32'(i == 4));
      if (i < 4) tick();
    end
    chk("ovf level full", 32'(fifo_level), 32'd4);
    chk("ovf err before edge", 32'(overflow_err), 32'd0);
    tick();
    chk("ovf err set", 32'(overflow_err), 32'd1);
    chk("ovf level held", 32'(fifo_level), 32'd4);
    chk("ovf read granted we", 32'(ram_we), 32'd0);
    chk("ovf stall held", 32'(cpu_stall), 32'd1);
    vga_req = 1'b0;
    #1;
    chk("ovf stall full registered", 32'(cpu_stall), 32'd1);
    tick();
    chk_wr("drain0", 6'd0, 8'hA0, 3'd3);
    chk("ovf stall released", 32'(cpu_stall), 32'd0);
    tick();
    chk_wr("drain1+push", 6'd1, 8'hA1, 3'd3);
    cpu_we = 1'b0;
    for (int k = 2; k < 5; k++) begin
      tick();
      chk_wr($sformatf("drain%0d", k), 6'(k), 8'(8'hA0 + k), 3'(4 - k));
    end
    tick();
    chk("drain done en", 32'(ram_en), 32'd0);
    chk("ovf err sticky", 32'(overflow_err), 32'd1);

    // Reset mid-traffic: 3 queued writes and reads in flight
    vga_req = 1'b1; vga_addr = 6'd9;
    for (int i = 0; i < 3; i++) begin
      cpu_we = 1'b1; cpu_addr = 32'h410 + 32'(i); cpu_wdata = 32'hC0 + 32'(i);
      tick();
    end
    cpu_we = 1'b0;
    chk("mid level3", 32'(fifo_level), 32'd3);
    @(posedge clock_50);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("midreset async");
    tick();
    tick();
    chk("midreset held en", 32'(ram_en), 32'd0);
    chk("midreset held rvalid", 32'(vga_rvalid), 32'd0);
    vga_req = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("post-reset%0d rvalid", c), 32'(vga_rvalid), 32'd0);
      chk($sformatf("post-reset%0d ram_en", c), 32'(ram_en), 32'd0);
      chk($sformatf("post-reset%0d level", c), 32'(fifo_level), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/char_ram_arbiter.md
Name: char_ram_arbiter

Overview:
Shares one single-port character RAM between two requesters: processor stores (write-only) and the VGA character fetch (read-only).
- VGA reads have absolute priority.
- Processor writes that fall inside the character window are buffered in a small FIFO and drained into the RAM on cycles with no VGA read.
- The block sits between the processor's WriteData/DataAdr/MemWrite bus, the VGA controller and the character RAM, all in the clock_50 domain.

Parameters:
DATA_W, 8, width of one character cell
ADDR_W, 6, character index width (41 cells used, 64 addressable)
N_CHARS, 41, number of valid cells; index >= N_CHARS is outside the window
BASE_ADDR, 32'h0000_0400, processor byte address of cell 0; one cell per byte
FIFO_DEPTH, 4, write-buffer entries (power of two)

Ports:
clock_50  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
cpu_we  in  1  processor store strobe (MemWrite)
cpu_addr  in  32  processor byte address (DataAdr)
cpu_wdata  in  32  processor store data (WriteData); low DATA_W bits used
cpu_stall  out  1  in-window store not accepted this cycle; processor must hold the store
vga_req  in  1  read request for one cell
vga_addr  in  ADDR_W  cell index to read
vga_rdata  out  DATA_W  read data
vga_rvalid  out  1  vga_rdata valid
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, 1-cycle latency after ram_en & !ram_we
fifo_level  out  3  occupied FIFO entries (0..FIFO_DEPTH)
overflow_err  out  1  sticky flag: a store hit a full FIFO

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0 and the FIFO is emptied.
  - A reset mid-operation discards pending writes and any read in flight; vga_rvalid does not assert for reads sampled before reset.
- Window decode: in_win = cpu_we & (cpu_addr >= BASE_ADDR) & (cpu_addr - BASE_ADDR < N_CHARS). Index = (cpu_addr - BASE_ADDR)[ADDR_W-1:0].
  - Out-of-window stores are ignored and never stall.
- Push: on a clock edge with in_win & !full, enqueue {index, cpu_wdata[DATA_W-1:0]}.
- cpu_stall:
  - Combinational: cpu_stall = in_win & full.
  - Full is the registered state, so a pop in the same cycle does not free a slot for that cycle's store.
  - On the first cycle of each stall episode, overflow_err is set; it clears only on reset.
- Per-cycle grant FSM, states GNT_IDLE, GNT_RD, GNT_WR; the state is registered and drives the ram_* outputs for the next cycle.
  - vga_req sampled 1 -> GNT_RD: ram_en=1, ram_we=0, ram_addr=vga_addr (registered).
  - Else FIFO non-empty -> GNT_WR: ram_en=1, ram_we=1, ram_addr/ram_wdata = head entry; the head is popped on the edge that enters GNT_WR.
  - Else -> GNT_IDLE: ram_en=0, ram_we=0; ram_addr and ram_wdata hold their last values.
- Read latency:
  - vga_req is sampled at edge t, the RAM is accessed in cycle t+1, and vga_rdata is registered from ram_rdata at edge t+2 with vga_rvalid=1 for one cycle.
  - Fixed 2 cycles; reads are fully pipelined, one per cycle.
- Write ordering:
  - FIFO order is preserved.
  - Two stores to the same index land in program order.
  - A VGA read of a cell with a pending write returns the old value; no bypass.
- Starvation: continuous vga_req blocks writes indefinitely. Drains occur during blanking. Processor stalls are the intended back-pressure.
- Simultaneous push and pop in one cycle with FIFO not full: level unchanged, both take effect.
- fifo_level is registered and updates on the same edge as push and pop.

Decomposition:
- Package char_ram_pkg:
  - DATA_W, ADDR_W, N_CHARS, BASE_ADDR
  - typedef wr_entry_t {logic [ADDR_W-1:0] idx; logic [DATA_W-1:0] data;}
  - enum grant_e {GNT_IDLE, GNT_RD, GNT_WR}
- One sub-module, sync_fifo: parameterised depth and width, push/pop/full/empty/level, asynchronous active-low reset. It is reusable elsewhere.
- Decode, grant FSM and read pipeline stay in char_ram_arbiter.

Test Plan:
- Reset pulse mid-traffic, with 3 entries queued and vga_req=1 -> all outputs 0 within the reset, fifo_level=0, no vga_rvalid afterwards until a new request.
- Store to 0x0000_0405 with data 0x41, vga_req=0 -> ram_we=1, ram_addr=5, ram_wdata=0x41 two edges after the store; fifo_level 1 then 0.
- vga_req=1 for addr 3, 4, 5 on consecutive cycles, with RAM model holding 0x10+index -> vga_rvalid on 3 consecutive cycles with data 0x13, 0x14, 0x15, each exactly 2 cycles after its request.
- vga_req held high while 5 in-window stores are issued -> 4 enqueue, 5th sees cpu_stall=1 and overflow_err=1; drop vga_req -> 4 writes drain in order, stall releases, 5th store completes.
- Stores to 0x0000_03FF, 0x0000_0429 (index 41) and 0x0000_0428 (index 40) -> first two ignored, no stall; only index 40 is written.
- Two stores to index 7 (0x01 then 0x02) followed by a read of index 7 after the drain -> vga_rdata=0x02.
